trainled2_chain_ctrl: RTL and testbench

Host-side frame sequencer for a daisy chain of TrainLED2 nodes. It holds one 24-bit colour word per node in an internal frame buffer, and on `start` serialises the whole buffer onto the single-wire chain input as pulse-width-coded bits. After the last bit it drives the line low for a latch gap so every node updates its three LED channels. It sits between the register/host logic and the `din` pin of the first TrainLED2 node.

---
 rtl/trainled2_chain_ctrl.sv | 131 +++++++++++++
 tb/tb_trainled2_chain_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trainled2_chain_ctrl.sv
// Frame sequencer for a TrainLED2 daisy chain: buffers one 24-bit colour word per node
// and serialises the whole buffer as pulse-width-coded bits followed by a latch gap.
module trainled2_chain_ctrl #(
    parameter int N_NODES = 4,
    parameter int AW      = 2,
    parameter int T0H     = 2,
    parameter int T1H     = 5,
    parameter int TBIT    = 8,
    parameter int TRESET  = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          start,
    output logic          dout,
    output logic          busy,
    output logic          done
);

    localparam int CW = $clog2(((TBIT > TRESET) ? TBIT : TRESET) + 1);

    localparam logic [CW-1:0] T0H_LAST    = CW'(T0H - 1);
    localparam logic [CW-1:0] T1H_LAST    = CW'(T1H - 1);
    localparam logic [CW-1:0] T0L_LAST    = CW'(TBIT - T0H - 1);
    localparam logic [CW-1:0] T1L_LAST    = CW'(TBIT - T1H - 1);
    localparam logic [CW-1:0] TRESET_LAST = CW'(TRESET - 1);
    localparam logic [AW-1:0] LAST_NODE   = AW'(N_NODES - 1);
    localparam logic [AW:0]   NODE_LIM    = (AW + 1)'(N_NODES);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        LATCH
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [4:0]    bit_idx, bit_nxt;
    logic [AW-1:0] node, node_nxt, node_inc;
    logic [23:0]   shreg, shreg_nxt;
    logic [23:0]   frame_buf [2**AW];
    logic [CW-1:0] hi_last, lo_last;
    logic          dout_nxt, busy_nxt, done_nxt;

    assign node_inc = node + 1'b1;
    assign hi_last  = shreg[23] ? T1H_LAST : T0H_LAST;
    assign lo_last  = shreg[23] ? T1L_LAST : T0L_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            node    <= '0;
            dout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            node    <= node_nxt;
            dout    <= dout_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // Loads read the pre-write buffer contents, so a same-cycle write lands in the next frame.
    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
        if (wr_en && ({1'b0, wr_addr} < NODE_LIM))
            frame_buf[wr_addr] <= wr_data;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        bit_nxt   = bit_idx;
        node_nxt  = node;
        shreg_nxt = shreg;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start) begin
                    shreg_nxt = frame_buf[0];
                    node_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (cnt == hi_last) begin
                    cnt_nxt   = '0;
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (cnt == lo_last) begin
                    cnt_nxt   = '0;
                    state_nxt = HIGH;
                    if (bit_idx != 5'd23) begin
                        bit_nxt   = bit_idx + 5'd1;
                        shreg_nxt = {shreg[22:0], 1'b0};
                    end else if (node != LAST_NODE) begin
                        node_nxt  = node_inc;
                        bit_nxt   = '0;
                        shreg_nxt = frame_buf[node_inc];
                    end else begin
                        state_nxt = LATCH;
                    end
                end
            end
            LATCH: begin
                if (cnt == TRESET_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        dout_nxt = (state_nxt == HIGH);
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_trainled2_chain_ctrl.sv
// Bench for trainled2_chain_ctrl: a 4-node and a 1-node instance checked every cycle against a
// timeline model of the frame, plus literal pulse-width, stream and handshake expectations.
module tb_trainled2_chain_ctrl;

    localparam int T0H = 2, T1H = 5, TBIT = 8, TRESET = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_en0 = 1'b0, wr_en1 = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        dout0, busy0, done0, dout1, busy1, done1;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;
    int cyc = 0;

    trainled2_chain_ctrl #(.N_NODES(4), .AW(3), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en0), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start0), .dout(dout0), .busy(busy0), .done(done0));

    trainled2_chain_ctrl #(.N_NODES(1), .AW(1), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_addr(wr_addr[0:0]), .wr_data(wr_data),
        .start(start1), .dout(dout1), .busy(busy1), .done(done1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Timeline model: frame position since the start edge determines every output.
    int          nn [2] = '{4, 1};
    logic [23:0] mbuf [2][8];
    bit          m_act [2];
    int          m_t [2];
    logic [23:0] m_word [2];
    bit          exp_dout [2], exp_busy [2], exp_done [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 1'b0; m_t[i] = 0;
                exp_dout[i] = 1'b0; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int nbits_cyc, frame, bp, ph, a;
                logic s, we;
                nbits_cyc = 24 * nn[i] * TBIT;
                frame = nbits_cyc + TRESET;
                s  = (i == 0) ? start0 : start1;
                we = (i == 0) ? wr_en0 : wr_en1;
                a  = (i == 0) ? int'(wr_addr) : int'(wr_addr[0]);
                exp_done[i] = 1'b0;
                if (m_act[i]) begin
                    m_t[i]++;
                    if (m_t[i] == frame) begin
                        m_act[i] = 1'b0;
                        exp_done[i] = 1'b1;
                    end
                end else if (s) begin
                    m_act[i] = 1'b1;
                    m_t[i] = 0;
                end
                exp_dout[i] = 1'b0;
                if (m_act[i] && m_t[i] < nbits_cyc) begin
                    bp = m_t[i] / TBIT;
                    if (m_t[i] % (24 * TBIT) == 0) m_word[i] = mbuf[i][bp / 24];
                    ph = m_t[i] % TBIT;
                    exp_dout[i] = ph < (m_word[i][23 - bp % 24] ? T1H : T0H);
                end
                exp_busy[i] = m_act[i];
                if (we && a < nn[i]) mbuf[i][a] = wr_data;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("dout0", 96'(dout0), 96'(exp_dout[0]));
            chk("busy0", 96'(busy0), 96'(exp_busy[0]));
            chk("done0", 96'(done0), 96'(exp_done[0]));
            chk("dout1", 96'(dout1), 96'(exp_dout[1]));
            chk("busy1", 96'(busy1), 96'(exp_busy[1]));
            chk("done1", 96'(done1), 96'(exp_done[1]));
        end
    end

    // Pulse-width and handshake monitors.
    int w0[$], w1[$];
    int run0 = 0, run1 = 0;
    int busy_cnt0 = 0, busy_cnt1 = 0, done_cnt0 = 0, done_cnt1 = 0;

    always @(negedge clk) begin
        if (dout0) run0++;
        else if (run0 > 0) begin w0.push_back(run0); run0 = 0; end
        if (dout1) run1++;
        else if (run1 > 0) begin w1.push_back(run1); run1 = 0; end
        if (busy0) busy_cnt0++;
        if (busy1) busy_cnt1++;
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
    end

    task automatic clear_mon();
        w0.delete(); w1.delete();
        run0 = 0; run1 = 0;
        busy_cnt0 = 0; busy_cnt1 = 0; done_cnt0 = 0; done_cnt1 = 0;
    endtask

    function automatic logic [95:0] dec0(input int off);
        logic [95:0] v = '0;
        for (int i = 0; i < 96; i++)
            if (off + i < w0.size()) v[95 - i] = (w0[off + i] > (T0H + T1H) / 2);
        return v;
    endfunction

    task automatic write0(input logic [2:0] a, input logic [23:0] d);
        wr_en0 = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en0 = 1'b0;
    endtask

    task automatic write1(input logic [2:0] a, input logic [23:0] d);
        wr_en1 = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en1 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget);
        int n = 0;
        while ((((which == 0) ? done0 : done1) !== 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 96'(n < budget), 96'(1));
    endtask

    int exp_w [24] = '{5, 2, 5, 2, 2, 5, 2, 5,
                       2, 2, 2, 2, 2, 2, 2, 2,
                       5, 5, 5, 5, 5, 5, 5, 5};
    int t0;

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dout", 96'(dout0), 96'(0));
        chk("rst_busy", 96'(busy0), 96'(0));
        chk("rst_done", 96'(done0), 96'(0));
        rst_n = 1'b1;
        check_en = 1'b1;
        @(negedge clk);

        write0(3'd0, 24'h000001);
        write0(3'd1, 24'h800000);
        write0(3'd2, 24'hFFFFFF);
        write0(3'd3, 24'h000000);
        write0(3'd4, 24'hDEADBE);
        write1(3'd0, 24'hA500FF);
        write1(3'd1, 24'h5A5A5A);
        repeat (2) @(negedge clk);

        // Single-node pattern
        clear_mon();
        start1 = 1'b1; @(negedge clk); start1 = 1'b0;
        wait_done(1, 400);
        repeat (3) @(negedge clk);
        chk("single_npulses", 96'(w1.size()), 96'(24));
        for (int i = 0; i < 24 && i < w1.size(); i++)
            chk("single_width", 96'(w1[i]), 96'(exp_w[i]));
        chk("single_busy", 96'(busy_cnt1), 96'(256));
        chk("single_done", 96'(done_cnt1), 96'(1));

        // Full chain, with start pulses ignored while busy
        clear_mon();
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        t0 = cyc;
        repeat (9) @(negedge clk);
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        repeat (489) @(negedge clk);
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        wait_done(0, 1000);
        chk("chain_done_at", 96'(cyc - t0), 96'(832));
        repeat (3) @(negedge clk);
        chk("chain_nbits", 96'(w0.size()), 96'(96));
        chk("chain_stream", dec0(0), {24'h000001, 24'h800000, 24'hFFFFFF, 24'h000000});
        chk("chain_busy", 96'(busy_cnt0), 96'(832));
        chk("chain_done", 96'(done_cnt0), 96'(1));

        // Write race during node 1
        clear_mon();
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        repeat (250) @(negedge clk);
        write0(3'd1, 24'h123456);
        write0(3'd2, 24'h654321);
        wait_done(0, 1000);
        repeat (3) @(negedge clk);
        chk("race_stream", dec0(0), {24'h000001, 24'h800000, 24'h654321, 24'h000000});

        // Back-to-back with start held
        clear_mon();
        start0 = 1'b1;
        @(negedge clk);
        wait_done(0, 1000);
        chk("b2b_busy_gap", 96'(busy0), 96'(0));
        @(negedge clk);
        chk("b2b_busy_rise", 96'(busy0), 96'(1));
        chk("b2b_dout_rise", 96'(dout0), 96'(1));
        start0 = 1'b0;
        wait_done(0, 1000);
        repeat (3) @(negedge clk);
        chk("b2b_nbits", 96'(w0.size()), 96'(192));
        chk("b2b_stream_a", dec0(0), {24'h000001, 24'h123456, 24'h654321, 24'h000000});
        chk("b2b_stream_b", dec0(96), {24'h000001, 24'h123456, 24'h654321, 24'h000000});
        chk("b2b_busy", 96'(busy_cnt0), 96'(1664));
        chk("b2b_done", 96'(done_cnt0), 96'(2));

        // Asynchronous reset mid-frame
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        repeat (100) @(negedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_busy", 96'(busy0), 96'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dout", 96'(dout0), 96'(0));
        chk("arst_busy", 96'(busy0), 96'(0));
        chk("arst_done", 96'(done0), 96'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_dout", 96'(dout0), 96'(0));
        chk("post_rst_busy", 96'(busy0), 96'(0));
        chk("post_rst_done", 96'(done0), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
